// File: rtl/i2c_byte_receiver_pkg.sv
// Shared definitions for the I2C byte receiver: FSM states, bus-level
// constants, default parameters and the address-match helper.
// Build option: I2C_GENERAL_CALL_EN also accepts the general-call
// address byte 8'h00 (write) alongside the configured slave address.
package i2c_byte_receiver_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } state_t;

    localparam logic [6:0] DEFAULT_SLAVE_ADDRESS = 7'h50;
    localparam int         DEFAULT_SYNC_STAGES   = 2;
    localparam logic [6:0] GENERAL_CALL_ADDRESS  = 7'h00;

    // R/W bit values as seen in bit 0 of the address byte
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // sda_oe values: pulling SDA low is an ACK, releasing it is a NACK
    localparam logic SDA_ACK  = 1'b1;
    localparam logic SDA_NACK = 1'b0;

`ifdef I2C_GENERAL_CALL_EN
    localparam logic GENERAL_CALL_ENABLED = 1'b1;
`else
    localparam logic GENERAL_CALL_ENABLED = 1'b0;
`endif

    // True when the received address byte addresses this device
    function automatic logic addr_match(input logic [7:0] addr_byte,
                                        input logic [6:0] own_address);
        logic own_hit;
        logic gc_hit;
        own_hit = (addr_byte[7:1] == own_address);
        gc_hit  = GENERAL_CALL_ENABLED &&
                  (addr_byte == {GENERAL_CALL_ADDRESS, RW_WRITE});
        return own_hit | gc_hit;
    endfunction

endpackage

// File: rtl/i2c_byte_receiver_if.sv
// Bus-side and user-side signals of the I2C byte receiver.
// The slave modport is the receiver's view; master is the environment's.
interface i2c_byte_receiver_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic       rx_ack_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rd_req;
    logic       start_det;
    logic       stop_det;
    logic       busy;

    modport slave (
        input  scl_in, sda_in, rx_ack_en,
        output sda_oe, rx_data, rx_valid, rd_req, start_det, stop_det, busy
    );

    modport master (
        output scl_in, sda_in, rx_ack_en,
        input  sda_oe, rx_data, rx_valid, rd_req, start_det, stop_det, busy
    );
endinterface

// File: rtl/i2c_byte_receiver_line_sync.sv
// Synchronizer and edge detector for one open-drain I2C line.
// Flops preset to the idle-high level; edges are suppressed until the
// chain has been refilled from the pad after reset, so a line that is
// already low at reset release does not look like a falling edge.
module i2c_line_sync
    import i2c_byte_receiver_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   history;
    logic [SYNC_STAGES:0]   primed;

    // Shift the pad through the synchronizer, keep one cycle of history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_chain <= '1;
            history    <= 1'b1;
            primed     <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], line_in};
            history    <= sync_chain[SYNC_STAGES-1];
            primed     <= {primed[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign level = sync_chain[SYNC_STAGES-1];
    assign rise  = primed[SYNC_STAGES] &  level & ~history;
    assign fall  = primed[SYNC_STAGES] & ~level &  history;

endmodule

// File: rtl/i2c_byte_receiver.sv
// I2C slave byte receiver: detects START/STOP, matches a 7-bit address,
// ACKs it, receives write data bytes MSB first and ACKs/NACKs each one
// according to rx_ack_en. Read addressing is flagged via rd_req only.
// Build option: I2C_GENERAL_CALL_EN (see i2c_byte_receiver_pkg).
module i2c_byte_receiver
    import i2c_byte_receiver_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDRESS = DEFAULT_SLAVE_ADDRESS,
    parameter int         SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
    input logic                clk,
    input logic                reset,
    i2c_byte_receiver_if.slave bus
);
    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk     (clk),
        .reset   (reset),
        .line_in (bus.scl_in),
        .level   (scl_level),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk     (clk),
        .reset   (reset),
        .line_in (bus.sda_in),
        .level   (sda_level),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    logic start_cond;
    logic stop_cond;
    assign start_cond = sda_fall & scl_level;
    assign stop_cond  = sda_rise & scl_level;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] shift;
    logic       rw_bit;
    logic       ack_phase;   // first SCL fall of the ACK slot already seen
    logic       ack_keep;    // rx_ack_en captured alongside rx_valid
    logic       drive_ack;
    logic [7:0] data_reg;
    logic       valid_pulse;
    logic       read_pulse;
    logic       start_pulse;
    logic       stop_pulse;
    logic       busy_flag;

    // Byte as it would look with the bit being sampled right now
    logic [7:0] byte_in;
    assign byte_in = {shift, sda_level};

    // Protocol FSM; START/STOP take priority over every state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            rw_bit      <= RW_WRITE;
            ack_phase   <= 1'b0;
            ack_keep    <= 1'b0;
            drive_ack   <= SDA_NACK;
            data_reg    <= '0;
            valid_pulse <= 1'b0;
            read_pulse  <= 1'b0;
            start_pulse <= 1'b0;
            stop_pulse  <= 1'b0;
            busy_flag   <= 1'b0;
        end else begin
            valid_pulse <= 1'b0;
            read_pulse  <= 1'b0;
            start_pulse <= 1'b0;
            stop_pulse  <= 1'b0;

            if (stop_cond) begin
                state      <= IDLE;
                bit_cnt    <= '0;
                ack_phase  <= 1'b0;
                drive_ack  <= SDA_NACK;
                busy_flag  <= 1'b0;
                stop_pulse <= 1'b1;
            end else if (start_cond) begin
                state       <= ADDR;
                bit_cnt     <= '0;
                ack_phase   <= 1'b0;
                drive_ack   <= SDA_NACK;
                start_pulse <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        drive_ack <= SDA_NACK;
                    end

                    ADDR: begin
                        if (scl_rise) begin
                            shift   <= byte_in[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (addr_match(byte_in, SLAVE_ADDRESS)) begin
                                    state      <= ADDR_ACK;
                                    busy_flag  <= 1'b1;
                                    rw_bit     <= byte_in[0];
                                    read_pulse <= (byte_in[0] == RW_READ);
                                end else begin
                                    state     <= IGNORE;
                                    busy_flag <= 1'b0;
                                end
                            end
                        end
                    end

                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                ack_phase <= 1'b1;
                                drive_ack <= SDA_ACK;
                            end else begin
                                ack_phase <= 1'b0;
                                drive_ack <= SDA_NACK;
                                bit_cnt   <= '0;
                                state     <= (rw_bit == RW_READ) ? IGNORE : DATA;
                            end
                        end
                    end

                    DATA: begin
                        if (scl_rise) begin
                            shift   <= byte_in[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                data_reg    <= byte_in;
                                valid_pulse <= 1'b1;
                                state       <= DATA_ACK;
                            end
                        end
                    end

                    DATA_ACK: begin
                        // The user answers in the same clk that rx_valid is seen
                        if (valid_pulse) begin
                            ack_keep <= bus.rx_ack_en;
                        end
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                ack_phase <= 1'b1;
                                drive_ack <= ack_keep ? SDA_ACK : SDA_NACK;
                            end else begin
                                ack_phase <= 1'b0;
                                drive_ack <= SDA_NACK;
                                bit_cnt   <= '0;
                                state     <= ack_keep ? DATA : IGNORE;
                            end
                        end
                    end

                    IGNORE: begin
                        drive_ack <= SDA_NACK;
                    end

                    default: begin
                        state     <= IDLE;
                        drive_ack <= SDA_NACK;
                    end
                endcase
            end
        end
    end

    assign bus.sda_oe    = drive_ack;
    assign bus.rx_data   = data_reg;
    assign bus.rx_valid  = valid_pulse;
    assign bus.rd_req    = read_pulse;
    assign bus.start_det = start_pulse;
    assign bus.stop_det  = stop_pulse;
    assign bus.busy      = busy_flag;

endmodule
